// File: rtl/register_file.sv
// 8 x 8 register file: one synchronous write port, two async read ports.
// Ports: clk, rst (sync, active-high), we/write_addr/write_data (write),
//        read_addr1/read_data1, read_addr2/read_data2 (combinational reads).
module register_file #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr1,
  input  logic [ADDR_WIDTH-1:0] read_addr2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      wr_sel;

  // One-hot write select; all zero when we is low.
  always_comb begin
    wr_sel = '0;
    if (we) begin
      wr_sel[write_addr] = 1'b1;
    end
  end

  // Per-entry storage; rst wins over a write in the same cycle.
  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        regs_q[i] <= '0;
      end else if (wr_sel[i]) begin
        regs_q[i] <= write_data;
      end
    end
  end

  // No write bypass: reads see the value before the edge.
  assign read_data1 = regs_q[read_addr1];
  assign read_data2 = regs_q[read_addr2];

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected reads,
// a monitor process samples both read ports and compares.
module tb_register_file;

  logic       clk;
  logic       rst;
  logic       we;
  logic [2:0] write_addr;
  logic [7:0] write_data;
  logic [2:0] read_addr1;
  logic [2:0] read_addr2;
  logic [7:0] read_data1;
  logic [7:0] read_data2;

  register_file dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .write_addr (write_addr),
    .write_data (write_data),
    .read_addr1 (read_addr1),
    .read_addr2 (read_addr2),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       c1;
    logic       c2;
    logic [7:0] e1;
    logic [7:0] e2;
  } exp_t;

  exp_t  exp_q  [$];
  string name_q [$];
  int    tests;
  int    fails;

  // Monitor: samples 1ns after each expectation is queued.
  initial begin
    exp_t  e;
    string n;
    forever begin
      wait (exp_q.size() != 0);
      #1;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      if (e.c1) begin
        tests++;
        if (read_data1 !== e.e1) begin
          fails++;
          $display("FAIL %s rd1: got %h want %h", n, read_data1, e.e1);
        end
      end
      if (e.c2) begin
        tests++;
        if (read_data2 !== e.e2) begin
          fails++;
          $display("FAIL %s rd2: got %h want %h", n, read_data2, e.e2);
        end
      end
    end
  end

  // Called at a negedge; returns at the following negedge.
  task automatic chk(input string n, input logic [2:0] a1,
                     input logic [2:0] a2, input logic c1,
                     input logic [7:0] e1, input logic c2,
                     input logic [7:0] e2);
    exp_t e;
    read_addr1 = a1;
    read_addr2 = a2;
    e.c1 = c1;
    e.c2 = c2;
    e.e1 = e1;
    e.e2 = e2;
    name_q.push_back(n);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    we         = 1'b1;
    write_addr = a;
    write_data = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    tests      = 0;
    fails      = 0;
    rst        = 1'b1;
    we         = 1'b0;
    write_addr = '0;
    write_data = '0;
    read_addr1 = '0;
    read_addr2 = '0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      chk("reset_state", 3'(i), 3'(7 - i), 1'b1, 8'h00, 1'b1, 8'h00);
    end

    wr(3'd0, 8'hAA);
    wr(3'd1, 8'h55);
    chk("basic", 3'd0, 3'd1, 1'b1, 8'hAA, 1'b1, 8'h55);

    we         = 1'b0;
    write_addr = 3'd0;
    write_data = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    chk("we_gate", 3'd0, 3'd1, 1'b1, 8'hAA, 1'b1, 8'h55);

    for (int i = 0; i < 8; i++) begin
      wr(3'(i), 8'(8'h10 + i));
    end
    chk("fill", 3'd3, 3'd7, 1'b1, 8'h13, 1'b1, 8'h17);
    rst        = 1'b1;
    we         = 1'b1;
    write_addr = 3'd7;
    write_data = 8'h77;
    @(negedge clk);
    rst = 1'b0;
    we  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("rst_dom", 3'(i), 3'(7 - i), 1'b1, 8'h00, 1'b1, 8'h00);
    end

    wr(3'd7, 8'h81);
    wr(3'd6, 8'h3C);
    chk("dual_same", 3'd7, 3'd7, 1'b1, 8'h81, 1'b1, 8'h81);
    read_addr2 = 3'd6;
    #1;
    chk("dual_diff", 3'd7, 3'd6, 1'b1, 8'h81, 1'b1, 8'h3C);

    wr(3'd2, 8'h11);
    we         = 1'b1;
    write_addr = 3'd2;
    write_data = 8'h22;
    chk("rdw_before", 3'd2, 3'd6, 1'b1, 8'h11, 1'b1, 8'h3C);
    we = 1'b0;
    chk("rdw_after", 3'd2, 3'd6, 1'b1, 8'h22, 1'b1, 8'h3C);

    for (int i = 0; i < 8; i++) begin
      wr(3'(i), 8'(i * 37));
    end
    for (int i = 0; i < 8; i++) begin
      v = 8'((7 - i) * 37);
      chk("sweep", 3'(i), 3'(7 - i), 1'b1, 8'(i * 37), 1'b1, v);
    end

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
